// File: rtl/adder_rs_pkg.sv
// adder_rs_pkg: shared tag width, ALU op encodings, adder unit code and reservation-station entry type.
package adder_rs_pkg;
  localparam int TAG_W = 6;
  localparam logic [2:0] ADDER_UNIT = 3'b000;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b100,
    OP_AND = 3'b101,
    OP_NOT = 3'b110,
    OP_XOR = 3'b111
  } alu_op_t;
  typedef struct packed {
    logic             busy;
    logic             dispatched;
    alu_op_t          op;
    logic [4:0]       dest;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } rs_entry_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op[2:1] != 2'b01;
  endfunction
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    return op == OP_SUB ? a - b :
           op == OP_OR  ? a | b :
           op == OP_AND ? a & b :
           op == OP_NOT ? ~a :
           op == OP_XOR ? a ^ b : a + b;
  endfunction
endpackage

// File: rtl/adder_rs_bank_if.sv
// adder_rs_bank_if: issue request and status/broadcast signals between the issuer and the adder RS bank.
interface adder_rs_bank_if;
  import adder_rs_pkg::*;
  logic             issue;
  logic [5:0]       operation;
  logic [4:0]       Dest_address;
  logic [4:0]       A_address;
  logic [4:0]       B_address;
  logic             adder_available;
  logic [TAG_W-1:0] adder_RS_available;
  logic             issue_error;
  logic [TAG_W-1:0] RS_issued;
  logic [TAG_W-1:0] RS_executing_adder;
  logic             adder_rts;
  logic [TAG_W-1:0] RS_finished;
  modport master (
    output issue, operation, Dest_address, A_address, B_address,
    input  adder_available, adder_RS_available, issue_error, RS_issued,
           RS_executing_adder, adder_rts, RS_finished
  );
  modport slave (
    input  issue, operation, Dest_address, A_address, B_address,
    output adder_available, adder_RS_available, issue_error, RS_issued,
           RS_executing_adder, adder_rts, RS_finished
  );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: valid/tag/result shift pipeline of depth ADD_LATENCY; the result is computed on entry.
module adder_pipe
  import adder_rs_pkg::*;
#(
  parameter int ADD_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [TAG_W-1:0] in_tag,
  input  alu_op_t          in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_result
);
  logic             valid [ADD_LATENCY];
  logic [TAG_W-1:0] tag   [ADD_LATENCY];
  logic [31:0]      res   [ADD_LATENCY];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ADD_LATENCY; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        res[i]   <= '0;
      end
    end else begin
      valid[0] <= in_tag != '0;
      tag[0]   <= in_tag;
      res[0]   <= alu(in_op, in_a, in_b);
      for (int i = 1; i < ADD_LATENCY; i++) begin
        valid[i] <= valid[i-1];
        tag[i]   <= tag[i-1];
        res[i]   <= res[i-1];
      end
    end
  end
  assign out_valid  = valid[ADD_LATENCY-1];
  assign out_tag    = tag[ADD_LATENCY-1];
  assign out_result = res[ADD_LATENCY-1];
endmodule

// File: rtl/adder_rs_bank.sv
// adder_rs_bank: adder reservation stations, register file and status table with CDB wakeup.
// Macro ADDER_RS_BYPASS_EN lets an issue capture the value broadcast at the same edge instead of being rejected.
module adder_rs_bank
  import adder_rs_pkg::*;
#(
  parameter int NUM_RS      = 3,
  parameter int ADD_LATENCY = 2
) (
  input logic            clock,
  input logic            reset_n,
  adder_rs_bank_if.slave bus
);
  rs_entry_t        rs     [NUM_RS];
  logic [31:0]      regs   [32];
  logic [TAG_W-1:0] status [32];
  logic [TAG_W-1:0] free_tag, ready_tag, exec_tag, bc_tag, qa, qb;
  alu_op_t          ready_op, exec_op;
  logic [31:0]      ready_a, ready_b, exec_a, exec_b, bc_result;
  logic [4:0]       bc_dest;
  logic             bc_valid, hit_a, hit_b, legal, accept;
  always_comb begin
    free_tag  = '0;
    ready_tag = '0;
    ready_op  = OP_ADD;
    ready_a   = '0;
    ready_b   = '0;
    bc_dest   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!rs[i].busy) free_tag = TAG_W'(i + 1);
      if (rs[i].busy && !rs[i].dispatched && rs[i].qj == '0 && rs[i].qk == '0) begin
        ready_tag = TAG_W'(i + 1);
        ready_op  = rs[i].op;
        ready_a   = rs[i].vj;
        ready_b   = rs[i].vk;
      end
      if (bc_tag == TAG_W'(i + 1)) bc_dest = rs[i].dest;
    end
  end
  // Sources are looked up before this edge's status update, so Dest==source sees the old producer.
  assign qa    = status[bus.A_address];
  assign qb    = status[bus.B_address];
  assign hit_a = bc_valid && qa == bc_tag;
  assign hit_b = bc_valid && qb == bc_tag;
  assign legal = bus.operation[5:3] == ADDER_UNIT && op_legal(bus.operation[2:0]);
`ifdef ADDER_RS_BYPASS_EN
  assign accept = bus.issue && legal && free_tag != '0;
`else
  assign accept = bus.issue && legal && free_tag != '0 && !hit_a && !hit_b;
`endif
  assign bus.adder_available    = free_tag != '0;
  assign bus.adder_RS_available = free_tag;
  assign bus.RS_executing_adder = exec_tag;
  assign bus.adder_rts          = bc_valid;
  assign bus.RS_finished        = bc_tag;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RS; i++) rs[i] <= '0;
      for (int i = 0; i < 32; i++) begin
        regs[i]   <= 32'(i);
        status[i] <= '0;
      end
      exec_tag        <= '0;
      exec_op         <= OP_ADD;
      exec_a          <= '0;
      exec_b          <= '0;
      bus.RS_issued   <= '0;
      bus.issue_error <= 1'b0;
    end else begin
      if (bc_valid && status[bc_dest] == bc_tag) begin
        regs[bc_dest]   <= bc_result;
        status[bc_dest] <= '0;
      end
      if (accept) status[bus.Dest_address] <= free_tag;
      for (int i = 0; i < NUM_RS; i++) begin
        if (bc_valid && rs[i].qj == bc_tag) begin
          rs[i].vj <= bc_result;
          rs[i].qj <= '0;
        end
        if (bc_valid && rs[i].qk == bc_tag) begin
          rs[i].vk <= bc_result;
          rs[i].qk <= '0;
        end
        if (ready_tag == TAG_W'(i + 1)) rs[i].dispatched <= 1'b1;
        if (bc_valid && bc_tag == TAG_W'(i + 1)) rs[i] <= '0;
        if (accept && free_tag == TAG_W'(i + 1))
          rs[i] <= '{busy: 1'b1, dispatched: 1'b0, op: alu_op_t'(bus.operation[2:0]),
                     dest: bus.Dest_address,
                     vj: hit_a ? bc_result : regs[bus.A_address],
                     vk: hit_b ? bc_result : regs[bus.B_address],
                     qj: hit_a ? TAG_W'(0) : qa,
                     qk: hit_b ? TAG_W'(0) : qb};
      end
      exec_tag        <= ready_tag;
      exec_op         <= ready_op;
      exec_a          <= ready_a;
      exec_b          <= ready_b;
      bus.RS_issued   <= accept ? free_tag : '0;
      bus.issue_error <= bus.issue && !accept;
    end
  end
  adder_pipe #(.ADD_LATENCY(ADD_LATENCY)) u_pipe (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_tag     (exec_tag),
    .in_op      (exec_op),
    .in_a       (exec_a),
    .in_b       (exec_b),
    .out_valid  (bc_valid),
    .out_tag    (bc_tag),
    .out_result (bc_result)
  );
endmodule

// File: tb/tb_adder_rs_bank.sv
// tb_adder_rs_bank: directed stimulus for adder_rs_bank, checked against a queue-based reservation-station model.
module tb_adder_rs_bank;
  localparam int N = 3;
  localparam int L = 2;
  logic clock;
  logic reset_n;
  adder_rs_bank_if bus ();
  adder_rs_bank #(.NUM_RS(N), .ADD_LATENCY(L)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int n_cmp = 0;
  int n_err = 0;
  bit model_ok = 0;
  bit          m_busy [N];
  bit          m_disp [N];
  logic [2:0]  m_op   [N];
  logic [4:0]  m_dest [N];
  logic [31:0] m_vj   [N];
  logic [31:0] m_vk   [N];
  int          m_qj   [N];
  int          m_qk   [N];
  logic [31:0] m_reg  [32];
  int          m_stat [32];
  int          q_tag [$];
  logic [31:0] q_val [$];
  int          q_cnt [$];
  int e_issued, e_exec, e_fin;
  bit e_err, e_rts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b100:  return a | b;
      3'b101:  return a & b;
      3'b110:  return ~a;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_disp[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'(i); m_stat[i] = 0;
    end
    q_tag.delete(); q_val.delete(); q_cnt.delete();
    e_issued = 0; e_exec = 0; e_fin = 0; e_err = 0; e_rts = 0;
  endtask

  task automatic model_step();
    int bt, fi, di, qa, qb;
    logic [31:0] bv, va, vb;
    bit ok;
    bt = 0; bv = 0; fi = -1; di = -1;
    if (q_tag.size() > 0 && q_cnt[0] == 0) begin
      bt = q_tag[0]; bv = q_val[0];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!m_busy[i]) fi = i;
      if (m_busy[i] && !m_disp[i] && m_qj[i] == 0 && m_qk[i] == 0) di = i;
    end
    qa = m_stat[bus.A_address]; va = m_reg[bus.A_address];
    qb = m_stat[bus.B_address]; vb = m_reg[bus.B_address];
    ok = bus.issue && bus.operation[5:3] == 3'b000 && bus.operation[2:1] != 2'b01 && fi >= 0;
`ifndef ADDER_RS_BYPASS_EN
    if (bt != 0 && (qa == bt || qb == bt)) ok = 0;
`endif
    if (bt != 0 && qa == bt) begin qa = 0; va = bv; end
    if (bt != 0 && qb == bt) begin qb = 0; vb = bv; end
    if (bt != 0) begin
      if (m_stat[m_dest[bt-1]] == bt) begin
        m_reg[m_dest[bt-1]] = bv; m_stat[m_dest[bt-1]] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] && m_qj[i] == bt) begin m_vj[i] = bv; m_qj[i] = 0; end
        if (m_busy[i] && m_qk[i] == bt) begin m_vk[i] = bv; m_qk[i] = 0; end
      end
      m_busy[bt-1] = 0;
      void'(q_tag.pop_front()); void'(q_val.pop_front()); void'(q_cnt.pop_front());
    end
    foreach (q_cnt[k]) q_cnt[k]--;
    e_exec = 0;
    if (di >= 0) begin
      m_disp[di] = 1;
      q_tag.push_back(di + 1); q_val.push_back(calc(m_op[di], m_vj[di], m_vk[di])); q_cnt.push_back(L);
      e_exec = di + 1;
    end
    if (ok) begin
      m_busy[fi] = 1; m_disp[fi] = 0; m_op[fi] = bus.operation[2:0]; m_dest[fi] = bus.Dest_address;
      m_vj[fi] = va; m_qj[fi] = qa; m_vk[fi] = vb; m_qk[fi] = qb;
      m_stat[bus.Dest_address] = fi + 1;
    end
    e_issued = ok ? fi + 1 : 0;
    e_err = bus.issue && !ok;
    e_rts = q_tag.size() > 0 && q_cnt[0] == 0;
    e_fin = e_rts ? q_tag[0] : 0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
    model_ok = 1;
  end

  always @(negedge clock) begin : cmp
    int lf;
    if (model_ok) begin
      lf = 0;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) lf = i + 1;
      chk("adder_available", bus.adder_available, lf != 0);
      chk("adder_RS_available", bus.adder_RS_available, lf);
      chk("issue_error", bus.issue_error, e_err);
      chk("RS_issued", bus.RS_issued, e_issued);
      chk("RS_executing_adder", bus.RS_executing_adder, e_exec);
      chk("adder_rts", bus.adder_rts, e_rts);
      chk("RS_finished", bus.RS_finished, e_fin);
    end
  end

  task automatic issue_op(input logic [5:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    bus.issue = 1'b1; bus.operation = op; bus.Dest_address = d; bus.A_address = a; bus.B_address = b;
    @(negedge clock);
    bus.issue = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 32; i++) chk($sformatf("reg R%0d", i), dut.regs[i], m_reg[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.issue = 1'b0; bus.operation = '0; bus.Dest_address = '0; bus.A_address = '0; bus.B_address = '0;
    idle(2);
    chk("reset adder_available", bus.adder_available, 1);
    chk("reset adder_RS_available", bus.adder_RS_available, 1);
    chk("reset RS_issued", bus.RS_issued, 0);
    chk("reset adder_rts", bus.adder_rts, 0);
    chk("reset RS_finished", bus.RS_finished, 0);
    chk("reset issue_error", bus.issue_error, 0);
    reset_n = 1'b1;
    // single add R1+R4->R2
    issue_op(6'b000000, 2, 1, 4);
    chk("t1 RS_issued", bus.RS_issued, 1);
    idle(1);
    chk("t1 RS_executing_adder", bus.RS_executing_adder, 1);
    idle(1);
    chk("t1 rts early", bus.adder_rts, 0);
    idle(1);
    chk("t1 adder_rts", bus.adder_rts, 1);
    chk("t1 RS_finished", bus.RS_finished, 1);
    idle(1);
    chk("t1 R2", dut.regs[2], 5);
    chk("t1 model R2", m_reg[2], 5);
    idle(2);
    // dependent chain R1+R4->R2, R2+R7->R3
    issue_op(6'b000000, 2, 1, 4);
    issue_op(6'b000000, 3, 2, 7);
    chk("t2 RS_issued", bus.RS_issued, 2);
    idle(1);
    chk("t2 waiting no exec", bus.RS_executing_adder, 0);
    idle(1);
    chk("t2 first finish", bus.RS_finished, 1);
    idle(2);
    chk("t2 second exec", bus.RS_executing_adder, 2);
    idle(2);
    chk("t2 second finish", bus.RS_finished, 2);
    idle(1);
    chk("t2 R3", dut.regs[3], 12);
    chk("t2 model R3", m_reg[3], 12);
    idle(2);
    // four back-to-back independent issues
    issue_op(6'b000100, 8, 5, 6);
    issue_op(6'b000001, 10, 9, 1);
    issue_op(6'b000111, 11, 3, 15);
    chk("t3 full", bus.adder_available, 0);
    issue_op(6'b000101, 14, 4, 13);
    chk("t3 issue_error", bus.issue_error, 1);
    chk("t3 no RS_issued", bus.RS_issued, 0);
    chk("t3 still full", bus.adder_available, 0);
    idle(1);
    chk("t3 RS1 free again", bus.adder_RS_available, 1);
    idle(8);
    chk("t3 R8", dut.regs[8], 7);
    chk("t3 R10", dut.regs[10], 8);
    chk("t3 R11", dut.regs[11], 3);
    // illegal opcodes, then a not
    issue_op(6'b000010, 17, 1, 1);
    chk("t4 bad alu_op error", bus.issue_error, 1);
    chk("t4 bad alu_op no issue", bus.RS_issued, 0);
    issue_op(6'b001000, 17, 1, 1);
    chk("t4 bad unit error", bus.issue_error, 1);
    chk("t4 bad unit no issue", bus.RS_issued, 0);
    issue_op(6'b000110, 16, 4, 9);
    idle(6);
    chk("t4 R16", dut.regs[16], 32'hFFFF_FFFB);
    chk("t4 R17 untouched", dut.regs[17], 17);
    // dependent issued exactly at the producer's broadcast edge
    issue_op(6'b000000, 20, 1, 1);
    idle(3);
    issue_op(6'b000000, 21, 20, 1);
`ifdef ADDER_RS_BYPASS_EN
    chk("t5 bypass issued", bus.RS_issued, 2);
    chk("t5 bypass no error", bus.issue_error, 0);
    idle(1);
    chk("t5 bypass exec", bus.RS_executing_adder, 2);
`else
    chk("t5 reject error", bus.issue_error, 1);
    chk("t5 reject no issue", bus.RS_issued, 0);
    issue_op(6'b000000, 21, 20, 1);
    chk("t5 retry issued", bus.RS_issued, 1);
    idle(1);
    chk("t5 retry exec", bus.RS_executing_adder, 1);
`endif
    idle(4);
    chk("t5 R21", dut.regs[21], 3);
    check_regs();
    idle(2);
    // reset with two ops in flight
    issue_op(6'b000000, 2, 1, 4);
    issue_op(6'b000000, 7, 5, 6);
    @(negedge clock);
    #2 reset_n = 1'b0;
    idle(2);
    #2 reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk("t6 no finish after reset", bus.RS_finished, 0);
    end
    chk("t6 R2", dut.regs[2], 2);
    chk("t6 R7", dut.regs[7], 7);
    chk("t6 all free", bus.adder_RS_available, 1);
    chk("t6 available", bus.adder_available, 1);
    check_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
